// File: rtl/alu_req_arbiter.sv
// Round-robin front end that shares one serial-protocol ALU among NUM_REQ requesters.
// Only one operation is in flight at a time. Each operation ends in a response pulse to its requester, either with the ALU result or with a timeout.
//
// state  | meaning
// IDLE   | no transaction; arbitrate among pending requests
// SEND_A | ack the granted requester; present opcode and operand A to the ALU
// SEND_B | present operand B to the ALU; clear the timeout counter
// WAIT   | wait for ALU done, or give up after TIMEOUT_CYCLES cycles
// RESP   | pulse rsp_valid to the granted requester; advance round-robin pointer
module alu_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_opcode,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic                          rsp_overflow,
  output logic                          rsp_timeout,
  output logic                          busy,
  output logic                          alu_opcode_valid,
  output logic                          alu_opcode,
  output logic [DATA_WIDTH-1:0]         alu_data,
  input  logic                          alu_done,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  input  logic                          alu_overflow
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEND_A = 3'd1,
    S_SEND_B = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]       g_q, g_d;
  logic                   op_q, op_d;
  logic [DATA_WIDTH-1:0]  a_q, a_d;
  logic [DATA_WIDTH-1:0]  b_q, b_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   ovf_q, ovf_d;
  logic                   tmo_q, tmo_d;

  logic                   found;
  logic [PTR_W-1:0]       grant_idx;

  // First pending request at or above rr_ptr, wrapping around
  always_comb begin
    int         pos;
    logic [PTR_W-1:0] pos_w;
    found     = 1'b0;
    grant_idx = '0;
    pos       = 0;
    pos_w     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos   = (int'(rr_ptr_q) + k) % NUM_REQ;
      pos_w = PTR_W'(pos);
      if (!found && req[pos_w]) begin
        found     = 1'b1;
        grant_idx = pos_w;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      g_q      <= '0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      g_q      <= g_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    g_d      = g_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    tmo_d    = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          g_d = grant_idx;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
              op_d = req_opcode[i];
              a_d  = req_a[i*DATA_WIDTH +: DATA_WIDTH];
              b_d  = req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          state_d = S_SEND_A;
        end
      end
      S_SEND_A: state_d = S_SEND_B;
      S_SEND_B: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done in the last allowed cycle still wins over the timeout
        if (alu_done) begin
          result_d = alu_result;
          ovf_d    = alu_overflow;
          tmo_d    = 1'b0;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          result_d = '0;
          ovf_d    = 1'b0;
          tmo_d    = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        rr_ptr_d = (g_q == PTR_W'(NUM_REQ - 1)) ? '0 : g_q + PTR_W'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack       = '0;
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i]       = (state_q == S_SEND_A) && (g_q == PTR_W'(i));
      rsp_valid[i] = (state_q == S_RESP)   && (g_q == PTR_W'(i));
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign alu_opcode_valid = (state_q == S_SEND_A);
  assign alu_opcode       = (state_q == S_SEND_A) && op_q;
  assign alu_data         = (state_q == S_SEND_A) ? a_q :
                            (state_q == S_SEND_B) ? b_q : '0;
  assign rsp_result       = (state_q == S_RESP) ? result_q : '0;
  assign rsp_overflow     = (state_q == S_RESP) && ovf_q;
  assign rsp_timeout      = (state_q == S_RESP) && tmo_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed self-checking bench for alu_req_arbiter (NUM_REQ=4, DATA_WIDTH=8, TIMEOUT_CYCLES=16).
// The bench plays the ALU itself, driving done/result by hand in each step.
module tb_alu_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, req_opcode;
  logic [31:0] req_a, req_b;
  logic [3:0]  ack, rsp_valid;
  logic [7:0]  rsp_result;
  logic        rsp_overflow, rsp_timeout, busy;
  logic        alu_opcode_valid, alu_opcode;
  logic [7:0]  alu_data;
  logic        alu_done;
  logic [7:0]  alu_result;
  logic        alu_overflow;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .ack(ack), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout),
    .busy(busy), .alu_opcode_valid(alu_opcode_valid), .alu_opcode(alu_opcode),
    .alu_data(alu_data), .alu_done(alu_done), .alu_result(alu_result),
    .alu_overflow(alu_overflow)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output logic [3:0] got, output int n);
    got = '0;
    n   = 0;
    while (got == 4'b0000 && n < 8) begin
      tick;
      n++;
      got = ack;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
    chk({tag, "_rsp_ovf"}, rsp_overflow, 0);
    chk({tag, "_rsp_tmo"}, rsp_timeout, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_opv"}, alu_opcode_valid, 0);
    chk({tag, "_op"}, alu_opcode, 0);
    chk({tag, "_data"}, alu_data, 0);
  endtask

  // One full transaction; ends sampled in the RESP cycle
  task automatic run_txn(input string tag, input logic [3:0] exp_g, input int exp_wait,
                         input logic [7:0] exp_a, input logic [7:0] exp_b, input logic exp_op,
                         input int k, input logic spur, input logic [7:0] res,
                         input logic ovf, input logic [3:0] req_after);
    logic [3:0] g;
    int         n;
    wait_ack(g, n);
    chk({tag, "_ack"}, g, exp_g);
    chk({tag, "_ack_lat"}, n, exp_wait);
    chk({tag, "_opv"}, alu_opcode_valid, 1);
    chk({tag, "_op"}, alu_opcode, exp_op);
    chk({tag, "_data_a"}, alu_data, exp_a);
    chk({tag, "_busy"}, busy, 1);
    req = req_after;
    tick;
    chk({tag, "_data_b"}, alu_data, exp_b);
    chk({tag, "_opv_b"}, alu_opcode_valid, 0);
    chk({tag, "_ack_b"}, ack, 0);
    if (spur) begin
      alu_done   = 1'b1;
      alu_result = 8'hEE;
    end
    tick;
    alu_done = 1'b0;
    for (int i = 1; i < k; i++) begin
      chk({tag, "_wait_rsp"}, rsp_valid, 0);
      chk({tag, "_wait_busy"}, busy, 1);
      tick;
    end
    alu_done     = 1'b1;
    alu_result   = res;
    alu_overflow = ovf;
    tick;
    alu_done     = 1'b0;
    alu_overflow = 1'b0;
    chk({tag, "_rsp_valid"}, rsp_valid, exp_g);
    chk({tag, "_rsp_result"}, rsp_result, res);
    chk({tag, "_rsp_ovf"}, rsp_overflow, ovf);
    chk({tag, "_rsp_tmo"}, rsp_timeout, 0);
  endtask

  initial begin
    logic [3:0] g;
    int         n;
    reset = 1'b1; req = '0; req_opcode = '0; req_a = '0; req_b = '0;
    alu_done = 1'b0; alu_result = '0; alu_overflow = 1'b0;
    #2;
    check_all_zero("reset");
    tick; tick;
    @(negedge clk) reset = 1'b0;
    tick;

    // Round robin with all requesters pending
    req_a = 32'h44332211; req_b = 32'h88776655; req_opcode = 4'b1010; req = 4'hF;
    run_txn("rr0",  4'b0001, 1, 8'h11, 8'h55, 1'b0, 1, 1'b0, 8'h66, 1'b0, 4'hF);
    run_txn("rr1",  4'b0010, 2, 8'h22, 8'h66, 1'b1, 1, 1'b0, 8'h88, 1'b0, 4'hF);
    run_txn("rr2",  4'b0100, 2, 8'h33, 8'h77, 1'b0, 1, 1'b0, 8'hAA, 1'b0, 4'hF);
    run_txn("rr3",  4'b1000, 2, 8'h44, 8'h88, 1'b1, 1, 1'b0, 8'hCC, 1'b0, 4'hF);
    run_txn("rr0b", 4'b0001, 2, 8'h11, 8'h55, 1'b0, 1, 1'b0, 8'h66, 1'b0, 4'hF);
    run_txn("rr1b", 4'b0010, 2, 8'h22, 8'h66, 1'b1, 1, 1'b0, 8'h88, 1'b0, 4'b1010);
    run_txn("rr3b", 4'b1000, 2, 8'h44, 8'h88, 1'b1, 1, 1'b0, 8'hCC, 1'b0, 4'b0000);
    tick;
    chk("busy_falls", busy, 0);

    // Single request, one-cycle ALU: 12 + 34
    req_opcode = 4'b0000;
    req_a = 32'h443322FF & 32'hFFFF0000 | 32'h0000FF12;
    req_b = 32'h88776601 & 32'hFFFF0000 | 32'h00000134;
    req = 4'b0001;
    run_txn("single", 4'b0001, 1, 8'h12, 8'h34, 1'b0, 1, 1'b0, 8'h46, 1'b0, 4'b0000);

    // Overflow: FF + 01 from requester 1
    req = 4'b0010;
    run_txn("ovf", 4'b0010, 2, 8'hFF, 8'h01, 1'b0, 1, 1'b0, 8'h00, 1'b1, 4'b0000);

    // Timeout: requester 2, ALU never signals done
    req = 4'b0100;
    wait_ack(g, n);
    chk("tmo_ack", g, 4'b0100);
    chk("tmo_ack_lat", n, 2);
    req = 4'b0000;
    alu_result = 8'hAA; alu_overflow = 1'b1;
    tick; tick;
    for (int i = 0; i < 15; i++) begin
      tick;
      chk("tmo_wait_rsp", rsp_valid, 0);
    end
    tick;
    chk("tmo_rsp_valid", rsp_valid, 4'b0100);
    chk("tmo_rsp_tmo", rsp_timeout, 1);
    chk("tmo_rsp_result", rsp_result, 0);
    chk("tmo_rsp_ovf", rsp_overflow, 0);
    alu_result = '0; alu_overflow = 1'b0;

    req = 4'b1000;
    run_txn("after_tmo", 4'b1000, 2, 8'h44, 8'h88, 1'b0, 1, 1'b0, 8'hCC, 1'b0, 4'b0000);

    // Spurious done during SEND_B is ignored
    req = 4'b0001;
    run_txn("spur", 4'b0001, 2, 8'h12, 8'h34, 1'b0, 2, 1'b1, 8'h46, 1'b0, 4'b0000);

    // Reset during WAIT
    req = 4'b0010;
    run_txn("pre_rst", 4'b0010, 2, 8'hFF, 8'h01, 1'b0, 1, 1'b0, 8'h00, 1'b1, 4'b0000);
    req = 4'b0100;
    wait_ack(g, n);
    chk("rst_ack", g, 4'b0100);
    req = 4'b0000;
    tick; tick;
    chk("rst_in_wait", busy, 1);
    #2 reset = 1'b1;
    #1;
    check_all_zero("rst_async");
    tick;
    chk("rst_hold_busy", busy, 0);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_no_rsp", rsp_valid, 0);
    end
    req = 4'b1001;
    run_txn("post_rst_ptr", 4'b0001, 1, 8'h12, 8'h34, 1'b0, 1, 1'b0, 8'h46, 1'b0, 4'b0000);
    tick;
    req = 4'b1000;
    run_txn("post_rst_r3", 4'b1000, 1, 8'h44, 8'h88, 1'b0, 1, 1'b0, 8'hCC, 1'b0, 4'b0000);
    tick;
    chk("end_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
